// File: rtl/flash_sched_pkg.sv
// rtl/flash_sched_pkg.sv - shared types and defaults for the flash read scheduler
// Purpose: scheduler state encoding, err_code values and the burst/gap defaults
//          shared with the flash master and byte-to-word packer.
// Ports:   none (package).
package flash_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_WAIT_SPACE = 3'd1,
      ST_ISSUE      = 3'd2,
      ST_WAIT_DONE  = 3'd3,
      ST_GAP        = 3'd4
   } sched_state_t;

   localparam logic [1:0] ERR_NONE     = 2'd0;
   localparam logic [1:0] ERR_BAD_LEN  = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
   localparam logic [1:0] ERR_BYTE_CNT = 2'd3;

   localparam int BURST_BYTES_DEF = 256;
   localparam int GAP_CYCLES_DEF  = 1000;

endpackage

// File: rtl/sched_timer.sv
// rtl/sched_timer.sv - loadable down-counter with terminal pulse
// Purpose: counts down from LOAD_VAL while enabled; tc is high during the
//          last enabled cycle (count == 1), so an enable window of exactly
//          LOAD_VAL cycles ends with tc.
// Ports:   spi_clk  clock
//          rst      asynchronous active-low reset
//          load     reload the counter with LOAD_VAL
//          en       count this cycle
//          tc       terminal pulse
module sched_timer #(
   parameter int W        = 16,
   parameter int LOAD_VAL = 1000
) (
   input  logic spi_clk,
   input  logic rst,
   input  logic load,
   input  logic en,
   output logic tc
);

   logic [W-1:0] cnt;

   always_ff @(posedge spi_clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= W'(LOAD_VAL);
      end else if (en && (cnt != '0)) begin
         cnt <= cnt - W'(1);
      end
   end

   assign tc = en && (cnt == W'(1));

endmodule

// File: rtl/flash_read_sched.sv
// rtl/flash_read_sched.sv - burst scheduler for the SPI-flash-to-FIFO path
// Purpose: splits a flash region into read bursts of up to BURST_BYTES, issues
//          one command per burst, throttles on FIFO back-pressure, enforces an
//          idle gap between commands and checks the returned byte count.
// Ports:   spi_clk, rst (async active-low)
//          start/abort/wrap_en, region_base/region_len   host control
//          fifo_full/prog_full                            FIFO back-pressure
//          flash_busy/byte_valid/flash_done               flash master status
//          flash_req/flash_addr/flash_len                 flash command
//          busy/done/err/err_code                         host status
module flash_read_sched #(
   parameter int ADDR_W         = 24,
   parameter int LEN_W          = 24,
   parameter int BURST_BYTES    = flash_sched_pkg::BURST_BYTES_DEF,
   parameter int BL_W           = 9,
   parameter int GAP_CYCLES     = flash_sched_pkg::GAP_CYCLES_DEF,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic              spi_clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic              wrap_en,
   input  logic [ADDR_W-1:0] region_base,
   input  logic [LEN_W-1:0]  region_len,
   input  logic              fifo_full,
   input  logic              prog_full,
   input  logic              flash_busy,
   input  logic              byte_valid,
   input  logic              flash_done,
   output logic              flash_req,
   output logic [ADDR_W-1:0] flash_addr,
   output logic [BL_W-1:0]   flash_len,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [1:0]        err_code
);

   import flash_sched_pkg::*;

   localparam int GW = $clog2(GAP_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   sched_state_t      state, state_nxt;
   logic [ADDR_W-1:0] base_q, cur_addr;
   logic [LEN_W-1:0]  len_q, remaining;
   logic              wrap_q, abort_pend;
   logic [BL_W-1:0]   byte_cnt, byte_cnt_nxt, burst_len;
   logic              len_bad, space_ok, cnt_ok;
   logic              gap_load, gap_tc, to_load, to_tc;

   assign len_bad      = (region_len == '0) || (region_len[1:0] != 2'b00);
   assign space_ok     = !prog_full && !fifo_full && !flash_busy;
   assign byte_cnt_nxt = byte_cnt + BL_W'(byte_valid);
   // Include a byte arriving in the same cycle as flash_done.
   assign cnt_ok       = (byte_cnt_nxt == flash_len);
   assign burst_len    = (remaining >= LEN_W'(BURST_BYTES)) ? BL_W'(BURST_BYTES)
                                                             : remaining[BL_W-1:0];
   assign busy         = (state != ST_IDLE);

   sched_timer #(.W(GW), .LOAD_VAL(GAP_CYCLES)) u_gap_timer (
      .spi_clk (spi_clk),
      .rst     (rst),
      .load    (gap_load),
      .en      (state == ST_GAP),
      .tc      (gap_tc)
   );

   sched_timer #(.W(TW), .LOAD_VAL(TIMEOUT_CYCLES)) u_timeout_timer (
      .spi_clk (spi_clk),
      .rst     (rst),
      .load    (to_load),
      .en      (state == ST_WAIT_DONE),
      .tc      (to_tc)
   );

   always_ff @(posedge spi_clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      flash_req = 1'b0;
      gap_load  = 1'b0;
      to_load   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start && !len_bad) state_nxt = ST_WAIT_SPACE;
         end
         ST_WAIT_SPACE: begin
            if (abort)         state_nxt = ST_IDLE;
            else if (space_ok) state_nxt = ST_ISSUE;
         end
         ST_ISSUE: begin
            flash_req = 1'b1;
            to_load   = 1'b1;
            state_nxt = ST_WAIT_DONE;
         end
         ST_WAIT_DONE: begin
            if (flash_done) begin
               gap_load  = cnt_ok;
               state_nxt = cnt_ok ? ST_GAP : ST_IDLE;
            end else if (to_tc) begin
               state_nxt = ST_IDLE;
            end
         end
         ST_GAP: begin
            if (abort) begin
               state_nxt = ST_IDLE;
            end else if (gap_tc) begin
               if (abort_pend || ((remaining == '0) && !wrap_q)) state_nxt = ST_IDLE;
               else                                               state_nxt = ST_WAIT_SPACE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge spi_clk or negedge rst) begin
      if (!rst) begin
         base_q     <= '0;
         len_q      <= '0;
         wrap_q     <= 1'b0;
         cur_addr   <= '0;
         remaining  <= '0;
         byte_cnt   <= '0;
         abort_pend <= 1'b0;
         flash_addr <= '0;
         flash_len  <= '0;
         done       <= 1'b0;
         err        <= 1'b0;
         err_code   <= ERR_NONE;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  base_q     <= region_base;
                  len_q      <= region_len;
                  wrap_q     <= wrap_en;
                  cur_addr   <= region_base;
                  remaining  <= region_len;
                  abort_pend <= 1'b0;
                  err        <= len_bad;
                  err_code   <= len_bad ? ERR_BAD_LEN : ERR_NONE;
               end
            end
            ST_WAIT_SPACE: begin
               // Command fields are loaded on entry to ISSUE and held until the next one.
               if (!abort && space_ok) begin
                  flash_addr <= cur_addr;
                  flash_len  <= burst_len;
               end
            end
            ST_ISSUE: begin
               byte_cnt <= '0;
               if (abort) abort_pend <= 1'b1;
            end
            ST_WAIT_DONE: begin
               byte_cnt <= byte_cnt_nxt;
               // Abort is deferred so the packer never sees a partial word.
               if (abort) abort_pend <= 1'b1;
               if (flash_done) begin
                  if (!cnt_ok) begin
                     err      <= 1'b1;
                     err_code <= ERR_BYTE_CNT;
                  end else begin
                     cur_addr  <= cur_addr + ADDR_W'(flash_len);
                     remaining <= remaining - LEN_W'(flash_len);
                  end
               end else if (to_tc) begin
                  err      <= 1'b1;
                  err_code <= ERR_TIMEOUT;
               end
            end
            ST_GAP: begin
               if (!abort && gap_tc && !abort_pend && (remaining == '0)) begin
                  if (wrap_q) begin
                     cur_addr  <= base_q;
                     remaining <= len_q;
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_flash_read_sched.sv
// tb/tb_flash_read_sched.sv - directed self-checking bench for flash_read_sched
module tb_flash_read_sched;

   localparam int TMO = 5000;

   logic        spi_clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0, abort = 1'b0, wrap_en = 1'b0;
   logic [23:0] region_base = '0;
   logic [23:0] region_len = '0;
   logic        fifo_full = 1'b0, prog_full = 1'b0;
   logic        flash_busy = 1'b0, byte_valid = 1'b0, flash_done = 1'b0;
   logic        flash_req;
   logic [23:0] flash_addr;
   logic [8:0]  flash_len;
   logic        busy, done, err;
   logic [1:0]  err_code;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int start_cyc, idle_cyc, rel_cyc, last_done_cyc = -1, done_cnt = 0, d0;
   bit model_short = 0, model_mute = 0;
   logic [23:0] req_addr[$];
   int          req_len[$];
   int          req_cyc[$];
   int          gaps[$];

   flash_read_sched #(.TIMEOUT_CYCLES(TMO)) dut (
      .spi_clk(spi_clk), .rst(rst), .start(start), .abort(abort), .wrap_en(wrap_en),
      .region_base(region_base), .region_len(region_len), .fifo_full(fifo_full),
      .prog_full(prog_full), .flash_busy(flash_busy), .byte_valid(byte_valid),
      .flash_done(flash_done), .flash_req(flash_req), .flash_addr(flash_addr),
      .flash_len(flash_len), .busy(busy), .done(done), .err(err), .err_code(err_code)
   );

   always #5 spi_clk = ~spi_clk;
   always @(posedge spi_clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Flash master model: streams flash_len bytes (one fewer if model_short), then flash_done.
   initial begin : flash_model
      forever begin
         @(negedge spi_clk);
         if (flash_req) begin
            int n;
            n = int'(flash_len) - (model_short ? 1 : 0);
            @(posedge spi_clk); #1 flash_busy = 1'b1;
            for (int i = 0; i < n; i++) begin
               @(posedge spi_clk); #1 byte_valid = 1'b1;
            end
            @(posedge spi_clk); #1 byte_valid = 1'b0;
            if (!model_mute) begin
               flash_done = 1'b1;
               @(posedge spi_clk); #1 flash_done = 1'b0;
            end
            flash_busy = 1'b0;
         end
      end
   end

   initial begin : monitor
      forever begin
         @(negedge spi_clk);
         if (flash_req) begin
            req_addr.push_back(flash_addr);
            req_len.push_back(int'(flash_len));
            req_cyc.push_back(cyc);
            if (last_done_cyc >= 0) gaps.push_back(cyc - last_done_cyc);
         end
         if (flash_done) last_done_cyc = cyc;
         if (done) done_cnt++;
      end
   end

   task automatic clear_log();
      req_addr.delete(); req_len.delete(); req_cyc.delete(); gaps.delete();
      last_done_cyc = -1;
   endtask

   task automatic do_start(input logic [23:0] base, input logic [23:0] len, input logic wrap);
      @(posedge spi_clk); #1;
      region_base = base; region_len = len; wrap_en = wrap; start = 1'b1;
      start_cyc = cyc;
      @(posedge spi_clk); #1 start = 1'b0;
   endtask

   task automatic pulse_abort();
      @(posedge spi_clk); #1 abort = 1'b1;
      @(posedge spi_clk); #1 abort = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input string tag);
      int n = 0;
      while (busy && n < budget) begin
         @(negedge spi_clk);
         n++;
      end
      idle_cyc = cyc;
      chk(tag, busy, 0);
   endtask

   task automatic wait_reqs(input int cnt, input int budget, input string tag);
      int n = 0;
      while (req_addr.size() < cnt && n < budget) begin
         @(negedge spi_clk);
         n++;
      end
      chk(tag, req_addr.size(), cnt);
   endtask

   initial begin
      repeat (4) @(posedge spi_clk);
      #1 rst = 1'b1;
      @(negedge spi_clk);
      chk("rst_busy", busy, 0);
      chk("rst_req", flash_req, 0);
      chk("rst_addr", flash_addr, 0);
      chk("rst_len", flash_len, 0);
      chk("rst_done", done, 0);
      chk("rst_err", {err, err_code}, 0);

      // 600-byte region: 256 + 256 + 88, start while busy must be ignored
      clear_log(); d0 = done_cnt;
      do_start(24'h000100, 24'd600, 1'b0);
      wait_reqs(1, 20, "r600_req1");
      @(posedge spi_clk); #1 start = 1'b1; region_base = 24'h005000; region_len = 24'd4;
      @(posedge spi_clk); #1 start = 1'b0;
      wait_idle(10000, "r600_idle");
      repeat (3) @(negedge spi_clk);
      chk("r600_nreq", req_addr.size(), 3);
      if (req_addr.size() == 3) begin
         chk("r600_a0", req_addr[0], 24'h000100);
         chk("r600_l0", req_len[0], 256);
         chk("r600_a1", req_addr[1], 24'h000200);
         chk("r600_l1", req_len[1], 256);
         chk("r600_a2", req_addr[2], 24'h000300);
         chk("r600_l2", req_len[2], 88);
         chk("r600_lat", req_cyc[0] - start_cyc, 2);
         chk("r600_gap1", gaps[0] >= 1002, 1);
         chk("r600_gap2", gaps[1] >= 1002, 1);
      end
      chk("r600_done", done_cnt - d0, 1);
      chk("r600_err", err, 0);

      // bad length
      clear_log();
      do_start(24'h0, 24'd6, 1'b0);
      @(negedge spi_clk);
      chk("len6_err", err, 1);
      chk("len6_code", err_code, 1);
      chk("len6_busy", busy, 0);
      repeat (10) @(negedge spi_clk);
      chk("len6_nreq", req_addr.size(), 0);

      // prog_full held during first burst and 5000 cycles
      clear_log(); d0 = done_cnt;
      do_start(24'h001000, 24'd512, 1'b0);
      wait_reqs(1, 20, "pf_req1");
      @(posedge spi_clk); #1 prog_full = 1'b1;
      repeat (5000) @(posedge spi_clk);
      #1 prog_full = 1'b0; rel_cyc = cyc;
      @(negedge spi_clk);
      chk("pf_hold", req_addr.size() == 1 || (req_addr.size() == 2 && req_cyc[1] > rel_cyc), 1);
      wait_reqs(2, 10, "pf_req2");
      if (req_cyc.size() == 2) chk("pf_resume", (req_cyc[1] - rel_cyc) inside {[1:2]}, 1);
      wait_idle(3000, "pf_idle");
      repeat (3) @(negedge spi_clk);
      chk("pf_err", err, 0);
      chk("pf_done", done_cnt - d0, 1);

      // short byte return
      clear_log(); model_short = 1;
      do_start(24'h0, 24'd512, 1'b0);
      wait_idle(2000, "short_idle");
      chk("short_code", err_code, 3);
      chk("short_err", err, 1);
      repeat (1500) @(negedge spi_clk);
      chk("short_nreq", req_addr.size(), 1);
      model_short = 0;

      // no flash_done at all
      clear_log(); model_mute = 1;
      do_start(24'h0, 24'd256, 1'b0);
      wait_idle(TMO + 1000, "tmo_idle");
      chk("tmo_code", err_code, 2);
      if (req_cyc.size() == 1) chk("tmo_time", (idle_cyc - req_cyc[0]) inside {[TMO:TMO + 5]}, 1);
      chk("tmo_nreq", req_addr.size(), 1);
      model_mute = 0;
      repeat (5) @(negedge spi_clk);

      // abort during burst 1 of 1024
      clear_log(); d0 = done_cnt;
      do_start(24'h0, 24'd1024, 1'b0);
      wait_reqs(1, 20, "ab_req1");
      repeat (20) @(posedge spi_clk);
      pulse_abort();
      chk("ab_still_busy", busy, 1);
      wait_idle(3000, "ab_idle");
      repeat (3) @(negedge spi_clk);
      chk("ab_nreq", req_addr.size(), 1);
      chk("ab_done", done_cnt - d0, 0);
      chk("ab_err", err, 0);
      chk("ab_after_gap", (idle_cyc - last_done_cyc) >= 1000, 1);

      // wrap across the top of the address space
      clear_log(); d0 = done_cnt;
      do_start(24'hFFFF00, 24'd512, 1'b1);
      wait_reqs(3, 6000, "wr_req3");
      pulse_abort();
      wait_idle(3000, "wr_idle");
      repeat (3) @(negedge spi_clk);
      if (req_addr.size() >= 3) begin
         chk("wr_a0", req_addr[0], 24'hFFFF00);
         chk("wr_a1", req_addr[1], 24'h000000);
         chk("wr_a2", req_addr[2], 24'hFFFF00);
      end
      chk("wr_done", done_cnt - d0, 0);

      // reset mid-burst
      clear_log();
      do_start(24'h0, 24'd256, 1'b0);
      wait_reqs(1, 20, "rb_req1");
      repeat (10) @(posedge spi_clk);
      #1 rst = 1'b0;
      @(negedge spi_clk);
      chk("rb_busy", busy, 0);
      chk("rb_len", flash_len, 0);
      #1 rst = 1'b1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/flash_read_sched.md
# flash_read_sched

Burst scheduler for the SPI-flash-to-FIFO streaming path. Reads a configured flash region as a series of fixed-size read bursts, issuing one read command per burst to the flash master. Throttles on FIFO back-pressure, inserts a mandatory idle gap between bursts and tracks returned bytes. Sits in the `spi_clk` domain between the host control registers and the flash master / byte-to-word packer.

## Interface
Parameters:
- `ADDR_W`, 24, flash byte-address width.
- `LEN_W`, 24, region-length width (bytes).
- `BURST_BYTES`, 256, maximum bytes per read command; must be a multiple of 4, ≤ 2^`BL_W`-1.
- `BL_W`, 9, burst-length field width.
- `GAP_CYCLES`, 1000, idle `spi_clk` cycles between consecutive commands.
- `TIMEOUT_CYCLES`, 65535, max cycles from command to `flash_done`.

Ports:
- `spi_clk` in 1: sole clock; all logic on posedge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse; latches region and begins.
- `abort` in 1: one-cycle pulse; stop after the current burst.
- `wrap_en` in 1: restart at `region_base` after region end (continuous stream).
- `region_base` in `ADDR_W`: first byte address.
- `region_len` in `LEN_W`: bytes to read; nonzero multiple of 4.
- `fifo_full` in 1, `prog_full` in 1: FIFO back-pressure.
- `flash_busy` in 1: flash master is executing a command.
- `byte_valid` in 1: one returned byte this cycle.
- `flash_done` in 1: one-cycle pulse, command complete.
- `flash_req` out 1: one-cycle command pulse.
- `flash_addr` out `ADDR_W`, `flash_len` out `BL_W`: command fields, held from `flash_req` until `flash_done`.
- `busy` out 1, `done` out 1 (one-cycle pulse), `err` out 1 (sticky until next `start`).
- `err_code` out 2: 0 none, 1 bad length, 2 timeout, 3 byte-count mismatch.

## Operation
- States: IDLE, WAIT_SPACE, ISSUE, WAIT_DONE, GAP.
- IDLE: on `start`, latch base, len, wrap_en; clear `err`/`err_code`. If len == 0 or len[1:0] != 0, set `err`, code 1, stay IDLE. Otherwise go WAIT_SPACE with cur_addr = base, remaining = len.
- WAIT_SPACE: wait until `!prog_full && !fifo_full && !flash_busy`, then go ISSUE.
- ISSUE (1 cycle): `flash_req`=1, `flash_addr`=cur_addr, `flash_len`=min(`BURST_BYTES`, remaining). Clear byte counter and timeout counter. Go WAIT_DONE.
- WAIT_DONE: count `byte_valid`; timeout counter increments each cycle.
  - On `flash_done`: if the byte count (including a `byte_valid` in the same cycle) != `flash_len`, set `err`, code 3, go IDLE.
  - Otherwise cur_addr += `flash_len` (modulo 2^`ADDR_W`) and remaining -= `flash_len`, then go GAP.
  - Timeout reaching `TIMEOUT_CYCLES` without `flash_done`: set `err`, code 2, go IDLE.
- GAP: count `GAP_CYCLES` cycles, then decide:
  - abort pending → IDLE, no `done`.
  - remaining == 0 and !wrap → IDLE with `done` pulse.
  - remaining == 0 and wrap → reload base/len, go WAIT_SPACE.
  - else → WAIT_SPACE.
- `abort` in WAIT_SPACE or GAP: go IDLE next cycle. In ISSUE/WAIT_DONE: set the abort-pending flag and finish the burst first, so the packer never sees a partial word. `abort` in IDLE is ignored.
- `start` while `busy` is ignored.
- `busy` = state != IDLE.

## Timing
- Reset: state IDLE. `flash_req`, `flash_addr`, `flash_len`, `busy`, `done`, `err`, `err_code` = 0. All counters 0.
- Back-pressure: `start` → `flash_req` = 2 cycles when there is no back-pressure.
- `flash_done` → next `flash_req` ≥ `GAP_CYCLES` + 2 cycles.
- `done` is asserted in the cycle IDLE is entered.
- `prog_full` rising during WAIT_DONE does not stop the current burst; it blocks only the next ISSUE.
- Reset mid-burst: immediate return to IDLE. The flash master and packer are reset by the same `rst`.

## Structure
- Shared package/header `flash_sched_pkg`:
  - state encoding;
  - `err_code` constants;
  - `BURST_BYTES` / `GAP_CYCLES` defaults, shared with the flash master and packer.
- One sub-module, `sched_timer`: a loadable down-counter with a terminal pulse, instantiated twice (gap and timeout).

## Test plan
- base=0x000100, len=600, no back-pressure → three `flash_req`:
  - (0x000100, 256), (0x000200, 256), (0x000300, 88);
  - ≥1002 cycles `flash_done`→`flash_req`;
  - one `done` pulse; `err`=0.
- len=6 → `err`=1, `err_code`=1 one cycle after `start`; no `flash_req`.
- Hold `prog_full`=1 for 5000 cycles after the first burst → no `flash_req` during that window; the second request follows within 2 cycles of release.
- Flash model returns 255 bytes for a 256-byte command → `err_code`=3, `busy`=0, no further requests. With no `flash_done` at all → `err_code`=2 after `TIMEOUT_CYCLES`.
- `abort` mid-WAIT_DONE of burst 1 (len=1024) → burst completes, no second `flash_req`, `done`=0, `busy` drops after the gap.
- wrap_en=1, base=0xFFFF00, len=512 → addresses 0xFFFF00, 0x000000, then 0xFFFF00 again; no `done`.
